// File: rtl/eth_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one Ethernet TX AXI-S channel
// between NUM_PORTS requesters. A granted port keeps the channel until its
// tlast beat is accepted; a single registered stage drives the MAC side.
module eth_tx_pkt_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned TDATA_WIDTH = 64,
  parameter int unsigned TUSER_WIDTH = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS-1:0]                   port_en,
  input  logic [NUM_PORTS-1:0]                   s_tvalid,
  output logic [NUM_PORTS-1:0]                   s_tready,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0]       s_tdata,
  input  logic [NUM_PORTS*(TDATA_WIDTH/8)-1:0]   s_tkeep,
  input  logic [NUM_PORTS-1:0]                   s_tlast,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0]       s_tuser,
  output logic                                   m_tvalid,
  input  logic                                   m_tready,
  output logic [TDATA_WIDTH-1:0]                 m_tdata,
  output logic [TDATA_WIDTH/8-1:0]               m_tkeep,
  output logic                                   m_tlast,
  output logic [TUSER_WIDTH-1:0]                 m_tuser,
  output logic                                   grant_vld,
  output logic [$clog2(NUM_PORTS)-1:0]           grant_idx,
  output logic [31:0]                            pkt_cnt
);

  localparam int unsigned IDX_W  = $clog2(NUM_PORTS);
  localparam int unsigned KEEP_W = TDATA_WIDTH / 8;

  typedef enum logic {ST_IDLE, ST_PKT} state_e;

  state_e                   state_q;
  logic [IDX_W-1:0]         grant_idx_q;
  logic [IDX_W-1:0]         last_winner_q;
  logic                     grant_vld_q;
  logic                     m_tvalid_q;
  logic [TDATA_WIDTH-1:0]   m_tdata_q;
  logic [KEEP_W-1:0]        m_tkeep_q;
  logic                     m_tlast_q;
  logic [TUSER_WIDTH-1:0]   m_tuser_q;
  logic [31:0]              pkt_cnt_q;

  logic [NUM_PORTS-1:0]     req;
  logic                     win_found;
  logic [IDX_W-1:0]         win_idx_d;
  logic [IDX_W-1:0]         cand;
  logic                     out_ready;
  logic                     sel_tvalid;
  logic                     sel_tlast;
  logic [TDATA_WIDTH-1:0]   sel_tdata;
  logic [KEEP_W-1:0]        sel_tkeep;
  logic [TUSER_WIDTH-1:0]   sel_tuser;
  logic                     beat_acc;

  // Round-robin search for the first enabled requester after last_winner.
  always_comb begin
    req       = s_tvalid & port_en;
    win_found = 1'b0;
    win_idx_d = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((32'(last_winner_q) + k) % NUM_PORTS);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx_d = cand;
      end
    end
  end

  // Mux the granted port's beat and derive the input handshake.
  always_comb begin
    out_ready  = ~m_tvalid_q | m_tready;
    sel_tvalid = s_tvalid[grant_idx_q];
    sel_tlast  = s_tlast[grant_idx_q];
    sel_tdata  = s_tdata[32'(grant_idx_q) * TDATA_WIDTH +: TDATA_WIDTH];
    sel_tkeep  = s_tkeep[32'(grant_idx_q) * KEEP_W +: KEEP_W];
    sel_tuser  = s_tuser[32'(grant_idx_q) * TUSER_WIDTH +: TUSER_WIDTH];
    beat_acc   = (state_q == ST_PKT) & sel_tvalid & out_ready;
    s_tready   = '0;
    if (state_q == ST_PKT) begin
      s_tready[grant_idx_q] = out_ready;
    end
  end

  // Grant FSM: pick a winner in IDLE, hold it until the tlast beat is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= '0;
      grant_vld_q   <= 1'b0;
      last_winner_q <= IDX_W'(NUM_PORTS - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            grant_idx_q   <= win_idx_d;
            last_winner_q <= win_idx_d;
            grant_vld_q   <= 1'b1;
            state_q       <= ST_PKT;
          end
        end
        ST_PKT: begin
          if (beat_acc && sel_tlast) begin
            grant_idx_q <= '0;
            grant_vld_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // MAC-side output register; holds its beat while the MAC stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= '0;
    end else if (beat_acc) begin
      m_tvalid_q <= 1'b1;
      m_tdata_q  <= sel_tdata;
      m_tkeep_q  <= sel_tkeep;
      m_tlast_q  <= sel_tlast;
      m_tuser_q  <= sel_tuser;
    end else if (m_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  // Count packets leaving on the MAC side; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q <= '0;
    end else if (m_tvalid_q && m_tready && m_tlast_q) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign m_tvalid  = m_tvalid_q;
  assign m_tdata   = m_tdata_q;
  assign m_tkeep   = m_tkeep_q;
  assign m_tlast   = m_tlast_q;
  assign m_tuser   = m_tuser_q;
  assign grant_vld = grant_vld_q;
  assign grant_idx = grant_idx_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_eth_tx_pkt_arbiter.sv
// Bench for eth_tx_pkt_arbiter: per-port packet queues drive the inputs, the
// MAC-side stream is logged and compared against packet-level expectations.
module tb_eth_tx_pkt_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   port_en, s_tvalid, s_tready, s_tlast, s_tuser;
  logic [N*64-1:0] s_tdata;
  logic [N*8-1:0] s_tkeep;
  logic           m_tvalid, m_tready, m_tlast, grant_vld;
  logic [63:0]    m_tdata;
  logic [7:0]     m_tkeep;
  logic [0:0]     m_tuser;
  logic [1:0]     grant_idx;
  logic [31:0]    pkt_cnt;

  eth_tx_pkt_arbiter #(.NUM_PORTS(N), .TDATA_WIDTH(64), .TUSER_WIDTH(1)) dut (
    .clk(clk), .rst(rst), .port_en(port_en), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .grant_vld(grant_vld), .grant_idx(grant_idx),
    .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // driver / observer state
  logic       rst_v = 1'b1;
  logic [3:0] en_v = 4'hF;
  logic       mr_v = 1'b1;
  int         vld_pct = 100;
  bit [N-1:0] hold;
  bit         prev_gv;
  logic [3:0] prev_req;
  int         pkt_seq[N];
  beat_t      src_q[N][$];
  beat_t      ref_q[N][$];
  beat_t      obs_q[$];
  int         obs_cyc[$];
  int         grant_log[$];
  logic [3:0] greq_log[$];

  function automatic int rr_pick(input int last, input logic [3:0] req);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit all_drained();
    for (int p = 0; p < N; p++)
      if (src_q[p].size() != 0 || ref_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, log handshakes.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    rst = rst_v;
    port_en = en_v;
    m_tready = mr_v;
    for (int p = 0; p < N; p++) begin
      if (!hold[p] && src_q[p].size() != 0 && $urandom_range(99) < vld_pct) hold[p] = 1'b1;
      if (hold[p]) b = src_q[p][0];
      else b = '0;
      s_tvalid[p] = hold[p];
      s_tdata[p*64 +: 64] = b.data;
      s_tkeep[p*8 +: 8] = b.keep;
      s_tlast[p] = b.last;
      s_tuser[p] = b.user;
    end
    #1;
    cyc++;
    if (m_tvalid && m_tready) begin
      b.data = m_tdata; b.keep = m_tkeep; b.last = m_tlast; b.user = m_tuser[0];
      obs_q.push_back(b);
      obs_cyc.push_back(cyc);
    end
    if (grant_vld && !prev_gv) begin
      grant_log.push_back(int'(grant_idx));
      greq_log.push_back(prev_req);
    end
    prev_gv = grant_vld;
    prev_req = s_tvalid & port_en;
    for (int p = 0; p < N; p++) begin
      if (s_tvalid[p] && s_tready[p]) begin
        void'(src_q[p].pop_front());
        hold[p] = 1'b0;
      end
    end
  endtask

  task automatic load_pkt(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {8'(p), 8'(pkt_seq[p]), 8'(i), 40'({$urandom(), $urandom()})};
      b.keep = 8'($urandom());
      b.user = 1'($urandom());
      b.last = (i == len - 1);
      src_q[p].push_back(b);
      ref_q[p].push_back(b);
    end
    pkt_seq[p]++;
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    for (int p = 0; p < N; p++) begin
      src_q[p].delete();
      ref_q[p].delete();
    end
    obs_q.delete(); obs_cyc.delete(); grant_log.delete(); greq_log.delete();
    hold = '0;
    en_v = 4'hF; mr_v = 1'b1; vld_pct = 100;
    tick();
    rst_v = 1'b0;
    tick();
  endtask

  task automatic run_until_obs(input int n, input int limit, output bit ok);
    for (int i = 0; i < limit && obs_q.size() < n; i++) tick();
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_v = 1'b1;
    tick();
    n_chk++; if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b, expected 0", m_tvalid); else n_pass++;
    n_chk++; if (s_tready !== 4'b0) $display("FAIL reset_s_tready: got %b, expected 0000", s_tready); else n_pass++;
    n_chk++; if (grant_vld !== 1'b0) $display("FAIL reset_grant_vld: got %b, expected 0", grant_vld); else n_pass++;
    n_chk++; if (grant_idx !== 2'd0) $display("FAIL reset_grant_idx: got %0d, expected 0", grant_idx); else n_pass++;
    n_chk++; if (pkt_cnt !== 32'd0) $display("FAIL reset_pkt_cnt: got %0d, expected 0", pkt_cnt); else n_pass++;
    n_chk++; if ({m_tdata, m_tkeep, m_tlast, m_tuser} !== '0) $display("FAIL reset_m_payload: got %h, expected 0", m_tdata); else n_pass++;
    rst_v = 1'b0;
    tick(); tick();
    n_chk++; if (grant_vld !== 1'b0) $display("FAIL idle_no_req_grant: got %b, expected 0", grant_vld); else n_pass++;
  endtask

  task automatic test_single_packet();
    bit ok;
    do_reset();
    load_pkt(0, 3);
    tick();
    tick();
    n_chk++; if (grant_vld !== 1'b1 || grant_idx !== 2'd0) $display("FAIL single_grant: got vld=%b idx=%0d, expected vld=1 idx=0", grant_vld, grant_idx); else n_pass++;
    run_until_obs(3, 20, ok);
    n_chk++; if (!ok) $display("FAIL single_timeout: got %0d beats, expected 3", obs_q.size()); else n_pass++;
    if (ok) begin
      n_chk++; if (obs_cyc[2] - obs_cyc[0] !== 2) $display("FAIL single_consecutive: got span %0d, expected 2", obs_cyc[2] - obs_cyc[0]); else n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_chk++; if (obs_q[i] !== ref_q[0][i]) $display("FAIL single_beat%0d: got %h, expected %h", i, obs_q[i], ref_q[0][i]); else n_pass++;
      end
    end
    tick();
    n_chk++; if (pkt_cnt !== 32'd1) $display("FAIL single_pkt_cnt: got %0d, expected 1", pkt_cnt); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    int cnt[N];
    int order[$];
    int last;
    logic [3:0] mask;
    beat_t e;
    beat_t exp_q[$];
    do_reset();
    cnt = '{2, 1, 1, 1};
    for (int p = 0; p < N; p++)
      for (int k = 0; k < cnt[p]; k++) load_pkt(p, 2);
    last = N - 1;
    for (int i = 0; i < 5; i++) begin
      for (int p = 0; p < N; p++) mask[p] = (cnt[p] > 0);
      last = rr_pick(last, mask);
      order.push_back(last);
      cnt[last]--;
    end
    foreach (order[i]) begin
      do begin
        e = ref_q[order[i]].pop_front();
        exp_q.push_back(e);
      end while (!e.last);
    end
    run_until_obs(10, 200, ok);
    n_chk++; if (!ok) $display("FAIL rr_timeout: got %0d beats, expected 10", obs_q.size()); else n_pass++;
    n_chk++; if (grant_log.size() !== 5) $display("FAIL rr_grant_count: got %0d, expected 5", grant_log.size()); else n_pass++;
    for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
      n_chk++; if (grant_log[i] !== order[i]) $display("FAIL rr_order%0d: got %0d, expected %0d", i, grant_log[i], order[i]); else n_pass++;
    end
    for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
      n_chk++; if (obs_q[i] !== exp_q[i]) $display("FAIL rr_beat%0d: got %h, expected %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    tick(); tick();
    n_chk++; if (pkt_cnt !== 32'd5) $display("FAIL rr_pkt_cnt: got %0d, expected 5", pkt_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    int i = 0;
    do_reset();
    load_pkt(1, 4);
    while (obs_q.size() < 4 && i < 60) begin
      mr_v = pat[i % 4];
      tick();
      i++;
      if (prev_stall) begin
        n_chk++; if (m_tvalid !== 1'b1 || m_tdata !== prev_data) $display("FAIL bp_hold: got vld=%b data=%h, expected vld=1 data=%h", m_tvalid, m_tdata, prev_data); else n_pass++;
      end
      if (m_tvalid && !m_tready) begin
        n_chk++; if (s_tready !== 4'b0) $display("FAIL bp_tready_stall: got %b, expected 0000", s_tready); else n_pass++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata;
    end
    mr_v = 1'b1;
    tick();
    n_chk++; if (obs_q.size() !== 4) $display("FAIL bp_beat_count: got %0d, expected 4", obs_q.size()); else n_pass++;
    for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
      n_chk++; if (obs_q[k] !== ref_q[1][k]) $display("FAIL bp_beat%0d: got %h, expected %h", k, obs_q[k], ref_q[1][k]); else n_pass++;
    end
  endtask

  task automatic test_port_enable();
    bit ok;
    do_reset();
    en_v = 4'b1101;
    load_pkt(1, 2);
    load_pkt(2, 3);
    tick();
    tick();
    n_chk++; if (grant_vld !== 1'b1 || grant_idx !== 2'd2) $display("FAIL en_grant: got vld=%b idx=%0d, expected vld=1 idx=2", grant_vld, grant_idx); else n_pass++;
    en_v = 4'b1001;
    run_until_obs(3, 30, ok);
    tick(); tick(); tick();
    n_chk++; if (!ok) $display("FAIL en_timeout: got %0d beats, expected 3", obs_q.size()); else n_pass++;
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      n_chk++; if (obs_q[k] !== ref_q[2][k]) $display("FAIL en_beat%0d: got %h, expected %h", k, obs_q[k], ref_q[2][k]); else n_pass++;
    end
    n_chk++; if (grant_vld !== 1'b0 || s_tready !== 4'b0) $display("FAIL en_idle: got vld=%b tready=%b, expected 0 0000", grant_vld, s_tready); else n_pass++;
    n_chk++; if (grant_log.size() !== 1) $display("FAIL en_grant_count: got %0d, expected 1", grant_log.size()); else n_pass++;
    n_chk++; if (pkt_cnt !== 32'd1) $display("FAIL en_pkt_cnt: got %0d, expected 1", pkt_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    int i;
    do_reset();
    load_pkt(1, 1);
    run_until_obs(1, 20, ok);
    tick();
    n_chk++; if (pkt_cnt !== 32'd1) $display("FAIL rstmid_pre_cnt: got %0d, expected 1", pkt_cnt); else n_pass++;
    load_pkt(2, 4);
    i = 0;
    while (src_q[2].size() > 2 && i < 40) begin tick(); i++; end
    n_chk++; if (src_q[2].size() !== 2) $display("FAIL rstmid_timeout: got %0d left, expected 2", src_q[2].size()); else n_pass++;
    rst_v = 1'b1;
    tick();
    n_chk++; if (m_tvalid !== 1'b0) $display("FAIL rstmid_m_tvalid: got %b, expected 0", m_tvalid); else n_pass++;
    n_chk++; if (s_tready !== 4'b0) $display("FAIL rstmid_s_tready: got %b, expected 0000", s_tready); else n_pass++;
    n_chk++; if (pkt_cnt !== 32'd0) $display("FAIL rstmid_pkt_cnt: got %0d, expected 0", pkt_cnt); else n_pass++;
    n_chk++; if (grant_vld !== 1'b0) $display("FAIL rstmid_grant_vld: got %b, expected 0", grant_vld); else n_pass++;
    do_reset();
    load_pkt(3, 1);
    load_pkt(1, 1);
    tick();
    tick();
    n_chk++; if (grant_vld !== 1'b1 || grant_idx !== 2'd1) $display("FAIL rstmid_first_grant: got vld=%b idx=%0d, expected vld=1 idx=1", grant_vld, grant_idx); else n_pass++;
  endtask

  task automatic test_counter_wrap();
    bit ok;
    do_reset();
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt_q;
    load_pkt(0, 2);
    run_until_obs(2, 20, ok);
    tick();
    n_chk++; if (pkt_cnt !== 32'd0) $display("FAIL wrap_to_zero: got %h, expected 00000000", pkt_cnt); else n_pass++;
    load_pkt(3, 1);
    run_until_obs(3, 20, ok);
    tick();
    n_chk++; if (pkt_cnt !== 32'd1) $display("FAIL wrap_next: got %h, expected 00000001", pkt_cnt); else n_pass++;
  endtask

  task automatic test_random();
    int last_w, owner, total, guard, g, w;
    int own_q[$];
    logic [3:0] r, allowed;
    beat_t b, e;
    bit prev_stall;
    logic [63:0] prev_data;
    do_reset();
    vld_pct = 60;
    total = 0;
    for (int p = 0; p < N; p++)
      for (int k = 0; k < 6; k++) begin
        load_pkt(p, $urandom_range(4, 1));
        total++;
      end
    last_w = N - 1; owner = -1; prev_stall = 1'b0; prev_data = '0; guard = 0;
    while (guard < 4000) begin
      en_v = 4'($urandom());
      mr_v = ($urandom_range(99) < 75);
      tick();
      guard++;
      allowed = grant_vld ? (4'b1 << grant_idx) : 4'b0;
      n_chk++; if ((s_tready & ~allowed) !== 4'b0) $display("FAIL rnd_tready_ungranted: got %b, allowed %b", s_tready, allowed); else n_pass++;
      if (grant_vld) begin
        n_chk++; if (s_tready[grant_idx] !== (!m_tvalid || m_tready)) $display("FAIL rnd_tready_granted: got %b, expected %b", s_tready[grant_idx], (!m_tvalid || m_tready)); else n_pass++;
      end else begin
        n_chk++; if (grant_idx !== 2'd0) $display("FAIL rnd_idx_idle: got %0d, expected 0", grant_idx); else n_pass++;
      end
      if (prev_stall) begin
        n_chk++; if (m_tvalid !== 1'b1 || m_tdata !== prev_data) $display("FAIL rnd_hold: got %h, expected %h", m_tdata, prev_data); else n_pass++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata;
      while (grant_log.size() != 0) begin
        g = grant_log.pop_front();
        r = greq_log.pop_front();
        w = rr_pick(last_w, r);
        n_chk++; if (g !== w) $display("FAIL rnd_rr: got %0d, expected %0d (req %b)", g, w, r); else n_pass++;
        last_w = g;
        own_q.push_back(g);
      end
      while (obs_q.size() != 0) begin
        b = obs_q.pop_front();
        void'(obs_cyc.pop_front());
        if (owner < 0 && own_q.size() != 0) owner = own_q.pop_front();
        n_chk++;
        if (owner < 0 || ref_q[owner].size() == 0) begin
          $display("FAIL rnd_unexpected_beat: got %h, expected none", b);
        end else begin
          e = ref_q[owner].pop_front();
          if (b !== e) $display("FAIL rnd_beat: got %h, expected %h", b, e); else n_pass++;
          if (e.last) owner = -1;
        end
      end
      if (all_drained() && !m_tvalid && !grant_vld) break;
    end
    n_chk++; if (guard >= 4000) $display("FAIL rnd_timeout: got %0d cycles, expected drain", guard); else n_pass++;
    tick();
    n_chk++; if (pkt_cnt !== 32'(total)) $display("FAIL rnd_pkt_cnt: got %0d, expected %0d", pkt_cnt, total); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    port_en = 4'hF; s_tvalid = '0; s_tdata = '0; s_tkeep = '0;
    s_tlast = '0; s_tuser = '0; m_tready = 1'b1;
    hold = '0; prev_gv = 1'b0; prev_req = '0;
    for (int p = 0; p < N; p++) pkt_seq[p] = 0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_port_enable();
    test_reset_mid_packet();
    test_counter_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
